data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core. It consumes the MemRead/MemWrite control bits and the address/store data produced downstream of the ID/EX register. It holds a word-addressed RAM, models a fixed access latency, and freezes the pipeline with stall_o until each access completes. Load data returns on rdata_o with a one-cycle done_o pulse.

Parameters:
LATENCY, 3, total stall cycles per aligned access; legal range 1..15.
DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words (default 256 words).

Ports:
clk_i  in  1  clock, all state updates on posedge
rst_i  in  1  synchronous active-high reset
MemRead_i  in  1  load request, level, held by the frozen pipeline while stall_o=1
MemWrite_i  in  1  store request, level, same hold rule
addr_i  in  32  byte address; word index = addr_i[DEPTH_LOG2+1:2]
wdata_i  in  32  store data
rdata_o  out  32  load data, registered, held until the next load completes
stall_o  out  1  combinational pipeline freeze
done_o  out  1  registered one-cycle completion pulse (load or store)
misalign_o  out  1  registered one-cycle pulse: request with addr_i[1:0]!=0 was dropped

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, cnt=0, rdata_o=0, done_o=0, misalign_o=0. RAM contents are not cleared.
- Reset mid-access: aborts the access. A pending store is not committed, and done_o does not pulse.
- States: IDLE, BUSY, DONE. Internal down-counter cnt is 4 bits.
- req = MemRead_i | MemWrite_i. Op = write if MemWrite_i=1 (write wins when both are set), else read.
- stall_o = (state==IDLE & req & aligned) | (state==BUSY). Never 1 in DONE.
- IDLE, aligned req:
  - Capture op, word index and wdata_i.
  - LATENCY==1: go to DONE.
  - Otherwise: cnt<=LATENCY-2, go to BUSY.
- IDLE, misaligned req: stay in IDLE, misalign_o<=1 for one cycle, stall_o=0, no RAM access, rdata_o unchanged.
  - A misaligned request held for N cycles pulses misalign_o on every one of those cycles.
- IDLE, no req: stay in IDLE.
- BUSY: if cnt==0 go to DONE, else cnt<=cnt-1. Inputs are ignored; captured values are used.
- Commit on the IDLE/BUSY->DONE edge:
  - Store: RAM[idx]<=wdata_cap.
  - Load: rdata_o<=RAM[idx].
  - done_o<=1 for exactly the DONE cycle.
- DONE: lasts one cycle, stall_o=0, and the pipeline advances. Inputs are never sampled in DONE, so the still-present old request is not re-accepted. DONE always goes to IDLE.
- Latency: a request first seen in IDLE at cycle t gives stall_o=1 on cycles t..t+LATENCY-1. done_o=1 and rdata_o are valid at cycle t+LATENCY.
- Back-to-back accesses: the earliest new request is accepted at t+LATENCY+1. Accesses never overlap.
- Read-after-write to the same word returns the new data, because the store commits before the next access can be captured.
- Address wrap: bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
- rdata_o is not updated by stores, misaligned requests or reset-aborted loads.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, no requests -> rdata_o=0, stall_o=0, done_o=0, misalign_o=0 throughout.
- Store then load, LATENCY=3:
  - Store wdata 0xDEADBEEF to addr 0x10 -> stall_o high for exactly 3 cycles, done_o pulse on the 4th.
  - Then load addr 0x10 -> rdata_o=0xDEADBEEF at done_o, stall_o high 3 cycles.
- Aliasing: store 0x12345678 to addr 0x404 with DEPTH_LOG2=8, then load addr 0x004 -> rdata_o=0x12345678.
- Misaligned: load addr 0x13, held 2 cycles -> misalign_o=1 on both cycles, stall_o=0, done_o=0, rdata_o unchanged.
- Mid-access reset: store 0xAAAA5555 to addr 0x20, rst_i=1 on the 2nd stall cycle -> next cycle state IDLE, stall_o=0, no done_o. A later load of 0x20 returns the prior contents, not 0xAAAA5555.
- LATENCY=1 and simultaneous requests:
  - MemRead_i=MemWrite_i=1 with wdata 0x0F0F0F0F to addr 0x8 -> one stall cycle, write performed, done_o next cycle, rdata_o unchanged.
  - Subsequent load of 0x8 -> 0x0F0F0F0F.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Multi-cycle data-memory responder for the MEM stage. A load or store is
// accepted in IDLE, the pipeline is frozen through stall_o for a fixed
// number of cycles, and the access commits on entry to DONE. DONE lasts a
// single cycle, in which done_o pulses and the pipeline advances.
//
// Ports
//   clk_i       clock, all state updates on the rising edge
//   rst_i       synchronous active-high reset
//   MemRead_i   load request (level, held while stall_o=1)
//   MemWrite_i  store request (level, wins over MemRead_i)
//   addr_i      byte address, word index = addr_i[DEPTH_LOG2+1:2]
//   wdata_i     store data
//   rdata_o     load data, held until the next load completes
//   stall_o     combinational pipeline freeze
//   done_o      one-cycle completion pulse
//   misalign_o  one-cycle pulse, a misaligned request was dropped
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, accepts aligned requests
// BUSY  | access in flight, cnt counts the remaining stall cycles down
// DONE  | access committed, done_o high, inputs not sampled
module data_mem_ctrl #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        misalign_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // The first stall cycle is spent in IDLE, so BUSY covers LATENCY-1
    // cycles, ending when the counter reaches zero.
    localparam logic [3:0] CNT_START = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  wr_cap;
    logic [DEPTH_LOG2-1:0] idx_cap;
    logic [31:0]           wdata_cap;
    logic [31:0]           mem [DEPTH];

    logic                  req;
    logic                  aligned;
    logic                  accept;
    logic                  go_done;
    logic [DEPTH_LOG2-1:0] idx_in;
    logic                  commit_wr;
    logic [DEPTH_LOG2-1:0] commit_idx;
    logic [31:0]           commit_wdata;
    logic                  unused_addr_bits;

    assign req     = MemRead_i | MemWrite_i;
    assign aligned = (addr_i[1:0] == 2'b00);
    assign idx_in  = addr_i[DEPTH_LOG2+1:2];
    assign accept  = (state == IDLE) && req && aligned;
    assign stall_o = accept || (state == BUSY);

    // Upper address bits alias onto the same words.
    assign unused_addr_bits = ^addr_i[31:DEPTH_LOG2+2];

    assign go_done = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd0));

    // With a single-cycle latency the commit happens on the accepting edge,
    // before the capture registers hold the request, so use the live inputs.
    assign commit_wr    = (state == IDLE) ? MemWrite_i : wr_cap;
    assign commit_idx   = (state == IDLE) ? idx_in     : idx_cap;
    assign commit_wdata = (state == IDLE) ? wdata_i    : wdata_cap;

    always_ff @(posedge clk_i) begin
        if (!rst_i && go_done && commit_wr) begin
            mem[commit_idx] <= commit_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_cap    <= MemWrite_i;
            idx_cap   <= idx_in;
            wdata_cap <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rdata_o    <= 32'd0;
            done_o     <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            done_o     <= go_done;
            misalign_o <= (state == IDLE) && req && !aligned;

            if (go_done && !commit_wr) begin
                rdata_o <= mem[commit_idx];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= CNT_START;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_rd, a_wr, a_stall, a_done, a_mis;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_rst, b_rd, b_wr, b_stall, b_done, b_mis;
    logic [31:0] b_addr, b_wdata, b_rdata;

    data_mem_ctrl #(.LATENCY(3), .DEPTH_LOG2(8)) u_dut_a (
        .clk_i      (clk),
        .rst_i      (a_rst),
        .MemRead_i  (a_rd),
        .MemWrite_i (a_wr),
        .addr_i     (a_addr),
        .wdata_i    (a_wdata),
        .rdata_o    (a_rdata),
        .stall_o    (a_stall),
        .done_o     (a_done),
        .misalign_o (a_mis)
    );

    data_mem_ctrl #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut_b (
        .clk_i      (clk),
        .rst_i      (b_rst),
        .MemRead_i  (b_rd),
        .MemWrite_i (b_wr),
        .addr_i     (b_addr),
        .wdata_i    (b_wdata),
        .rdata_o    (b_rdata),
        .stall_o    (b_stall),
        .done_o     (b_done),
        .misalign_o (b_mis)
    );

    typedef struct {
        logic        is_mis;
        logic [31:0] rdata;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every done/misalign pulse must match the head
    // of the expectation queue of its DUT.
    always @(negedge clk) begin
        if (mon_en && (a_done || a_mis)) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_pulse: done=%0b misalign=%0b rdata=0x%08h, no pulse expected",
                         a_done, a_mis, a_rdata);
            end else begin
                ea = qa.pop_front();
                check("a_pulse_kind", {30'd0, a_done, a_mis}, {30'd0, !ea.is_mis, ea.is_mis});
                check("a_rdata", a_rdata, ea.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && (b_done || b_mis)) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_pulse: done=%0b misalign=%0b rdata=0x%08h, no pulse expected",
                         b_done, b_mis, b_rdata);
            end else begin
                eb = qb.pop_front();
                check("b_pulse_kind", {30'd0, b_done, b_mis}, {30'd0, !eb.is_mis, eb.is_mis});
                check("b_rdata", b_rdata, eb.rdata);
            end
        end
    end

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        end
    endtask

    function automatic logic stall_of(input bit sel);
        return sel ? b_stall : a_stall;
    endfunction

    // One aligned access; counts stall cycles and queues the expected
    // done pulse. With scramble set, addr/wdata change during the stall.
    task automatic access(input bit sel, input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int exp_stall, input bit scramble);
        exp_t e;
        int   n;
        e.is_mis = 1'b0;
        e.rdata  = exp_rdata;
        if (sel) qb.push_back(e); else qa.push_back(e);
        @(posedge clk); #1;
        drive(sel, rd, wr, addr, wdata);
        n = 0;
        @(negedge clk);
        while (stall_of(sel) && n < 40) begin
            n++;
            if (scramble) begin
                @(posedge clk); #1;
                drive(sel, rd, wr, $urandom & 32'hFFFF_FFFC, $urandom);
            end
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic misaligned(input bit sel, input logic [31:0] addr,
                              input logic [31:0] exp_rdata, input int hold);
        exp_t e;
        e.is_mis = 1'b1;
        e.rdata  = exp_rdata;
        for (int i = 0; i < hold; i++) begin
            if (sel) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge clk); #1;
        drive(sel, 1'b1, 1'b0, addr, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("mis_stall", 32'(stall_of(sel)), 32'd0);
            @(posedge clk); #1;
        end
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_rst = 1'b1;
        b_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            check("rst_a_outs", {a_rdata[29:0], a_stall, a_done | a_mis}, 32'd0);
            check("rst_b_outs", {b_rdata[29:0], b_stall, b_done | b_mis}, 32'd0);
        end
        @(posedge clk); #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_a_rdata", a_rdata, 32'd0);
            check("idle_a_flags", {29'd0, a_stall, a_done, a_mis}, 32'd0);
            check("idle_b_flags", {29'd0, b_stall, b_done, b_mis}, 32'd0);
        end
        mon_en = 1'b1;

        // LATENCY=3 instance
        access(1'b0, "st_10",    1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        3, 1'b0);
        access(1'b0, "ld_10",    1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 3, 1'b0);
        access(1'b0, "st_404",   1'b0, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 3, 1'b0);
        access(1'b0, "ld_004",   1'b1, 1'b0, 32'h004, 32'h0,        32'h12345678, 3, 1'b0);
        misaligned(1'b0, 32'h13, 32'h12345678, 2);
        access(1'b0, "st_20",    1'b0, 1'b1, 32'h20,  32'h11112222, 32'h12345678, 3, 1'b0);
        access(1'b0, "st_40_scr",1'b0, 1'b1, 32'h40,  32'hCAFEF00D, 32'h12345678, 3, 1'b1);
        access(1'b0, "ld_40",    1'b1, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D, 3, 1'b0);

        // Store to 0x20 aborted by reset on its second stall cycle
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hAAAA5555);
        @(negedge clk);
        check("abort_stall_c0", 32'(a_stall), 32'd1);
        @(posedge clk); #1;
        a_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("abort_stall_c1", 32'(a_stall), 32'd1);
        @(posedge clk); #1;
        a_rst = 1'b0;
        @(negedge clk);
        check("abort_after_flags", {29'd0, a_stall, a_done, a_mis}, 32'd0);
        check("abort_after_rdata", a_rdata, 32'd0);
        repeat (3) @(negedge clk);

        access(1'b0, "ld_20",    1'b1, 1'b0, 32'h20,  32'h0,        32'h11112222, 3, 1'b0);
        access(1'b0, "ld_10_b",  1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 3, 1'b0);

        // LATENCY=1 instance, simultaneous read/write then load
        access(1'b1, "b_rw_8",   1'b1, 1'b1, 32'h8,   32'h0F0F0F0F, 32'h0,        1, 1'b0);
        access(1'b1, "b_ld_8",   1'b1, 1'b0, 32'h8,   32'h0,        32'h0F0F0F0F, 1, 1'b0);
        misaligned(1'b1, 32'h6, 32'h0F0F0F0F, 1);

        repeat (5) @(negedge clk);
        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
